// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C master bit/byte controller: command codes,
// controller states, SCL drive modes and legal prescaler bounds.
package i2c_master_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_e;

  // ST_LAUNCH holds SCL low with a command latched, waiting for the FALL strobe
  // so SCL re-enters RUN mode without a glitch.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START_A = 4'd1,
    ST_START_B = 4'd2,
    ST_HOLD    = 4'd3,
    ST_LAUNCH  = 4'd4,
    ST_DATA    = 4'd5,
    ST_ACK     = 4'd6,
    ST_RSTART  = 4'd7,
    ST_STOP_A  = 4'd8,
    ST_STOP_B  = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    SCL_MODE_IDLE = 2'd0,
    SCL_MODE_RUN  = 2'd1,
    SCL_MODE_HOLD = 2'd2
  } scl_mode_e;

  localparam logic [7:0] PRESCALER_MIN = 8'd2;
  localparam logic [7:0] PRESCALER_MAX = 8'd128;

endpackage

// File: rtl/i2c_phase_decode.sv
// Decodes the clock generator's down-counting phase counter into the three
// strobes the controller acts on: SCL fall, low-phase middle, high-phase middle.
module i2c_phase_decode (
  input  logic [7:0] prescaler_i,
  input  logic [7:0] counter_detect_edge_i,
  output logic       fall_o,
  output logic       lo_mid_o,
  output logic       hi_mid_o
);

  logic [8:0] p9;
  logic [8:0] half9;
  logic [8:0] cde9;

  // 9-bit arithmetic keeps P + P/2 exact for P up to 128.
  assign p9    = {1'b0, prescaler_i};
  assign half9 = p9 >> 1;
  assign cde9  = {1'b0, counter_detect_edge_i};

  assign fall_o   = (cde9 == p9);
  assign lo_mid_o = (cde9 == half9);
  assign hi_mid_o = (cde9 == (p9 + half9));

endmodule

// File: rtl/i2c_bit_byte_ctrl.sv
// I2C master bit/byte engine: turns START/WRITE/READ/STOP commands into SDA
// open-drain enables and a gated SCL, timed off the free-running SCL generator.
module i2c_bit_byte_ctrl
  import i2c_master_pkg::*;
(
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic [7:0] prescaler_i,
  input  logic       scl_i,
  input  logic [7:0] counter_detect_edge_i,
  input  logic       cmd_valid_i,
  input  logic [1:0] cmd_i,
  input  logic [7:0] tx_data_i,
  input  logic       ack_tx_i,
  input  logic       sda_i,
  output logic       cmd_ready_o,
  output logic       done_o,
  output logic [7:0] rx_data_o,
  output logic       ack_rx_o,
  output logic       sda_oe_o,
  output logic       scl_bus_o,
  output logic       busy_o
);

  state_e    state_q, state_d;
  scl_mode_e scl_mode_q, scl_mode_d;
  cmd_e      cmd_q, cmd_d;
  logic      sda_oe_q, sda_oe_d;
  logic      done_q, done_d;
  logic [7:0] tx_q, tx_d;
  logic      ack_tx_q, ack_tx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic      ack_rx_q, ack_rx_d;

  logic fall, lo_mid, hi_mid;
  logic p_legal;
  logic accept;

  i2c_phase_decode u_phase_decode (
    .prescaler_i           (prescaler_i),
    .counter_detect_edge_i (counter_detect_edge_i),
    .fall_o                (fall),
    .lo_mid_o              (lo_mid),
    .hi_mid_o              (hi_mid)
  );

  assign p_legal     = (prescaler_i >= PRESCALER_MIN) && (prescaler_i <= PRESCALER_MAX);
  assign cmd_ready_o = p_legal && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    scl_mode_d = scl_mode_q;
    cmd_d      = cmd_q;
    sda_oe_d   = sda_oe_q;
    done_d     = 1'b0;
    tx_d       = tx_q;
    ack_tx_d   = ack_tx_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    ack_rx_d   = ack_rx_q;

    case (state_q)
      ST_IDLE: begin
        // Only START makes sense on a free bus; anything else completes as a no-op.
        if (accept) begin
          if (cmd_e'(cmd_i) == CMD_START) state_d = ST_START_A;
          else                             done_d  = 1'b1;
        end
      end
      ST_START_A: begin
        if (hi_mid) begin
          sda_oe_d = 1'b1;
          state_d  = ST_START_B;
        end
      end
      ST_START_B: begin
        if (fall) begin
          scl_mode_d = SCL_MODE_HOLD;
          done_d     = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          cmd_d    = cmd_e'(cmd_i);
          tx_d     = tx_data_i;
          ack_tx_d = ack_tx_i;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (fall) begin
          scl_mode_d = SCL_MODE_RUN;
          bit_cnt_d  = 3'd7;
          case (cmd_q)
            CMD_START: state_d = ST_RSTART;
            CMD_STOP:  state_d = ST_STOP_A;
            default:   state_d = ST_DATA;
          endcase
        end
      end
      ST_DATA: begin
        if (lo_mid) sda_oe_d = (cmd_q == CMD_WRITE) ? ~tx_q[bit_cnt_q] : 1'b0;
        if (hi_mid) rx_shift_d = {rx_shift_q[6:0], sda_i};
        if (fall) begin
          if (bit_cnt_q == 3'd0) state_d   = ST_ACK;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ST_ACK: begin
        if (lo_mid) sda_oe_d = (cmd_q == CMD_WRITE) ? 1'b0 : ~ack_tx_q;
        if (hi_mid && (cmd_q == CMD_WRITE)) ack_rx_d = sda_i;
        if (fall) begin
          scl_mode_d = SCL_MODE_HOLD;
          if (cmd_q == CMD_READ) rx_data_d = rx_shift_q;
          done_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_RSTART: begin
        if (lo_mid) sda_oe_d = 1'b0;
        if (hi_mid) sda_oe_d = 1'b1;
        if (fall) begin
          scl_mode_d = SCL_MODE_HOLD;
          done_d     = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_STOP_A: begin
        if (lo_mid) sda_oe_d = 1'b1;
        if (hi_mid) begin
          sda_oe_d = 1'b0;
          state_d  = ST_STOP_B;
        end
      end
      ST_STOP_B: begin
        if (fall) begin
          scl_mode_d = SCL_MODE_IDLE;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      state_q    <= ST_IDLE;
      scl_mode_q <= SCL_MODE_IDLE;
      cmd_q      <= CMD_START;
      sda_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= 8'h00;
      ack_tx_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      ack_rx_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      scl_mode_q <= scl_mode_d;
      cmd_q      <= cmd_d;
      sda_oe_q   <= sda_oe_d;
      done_q     <= done_d;
      tx_q       <= tx_d;
      ack_tx_q   <= ack_tx_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      ack_rx_q   <= ack_rx_d;
    end
  end

  // Mode switches into/out of RUN coincide with the generator's own fall,
  // so the gated SCL never glitches high.
  always_comb begin
    case (scl_mode_q)
      SCL_MODE_IDLE: scl_bus_o = 1'b1;
      SCL_MODE_RUN:  scl_bus_o = scl_i;
      default:       scl_bus_o = 1'b0;
    endcase
  end

  assign sda_oe_o  = sda_oe_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign ack_rx_o  = ack_rx_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule
